// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - rx state encodings, oversampling constants and ASCII helpers
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam int         OVERSAMPLE    = 16;
  localparam logic [3:0] MID_SAMPLE    = 4'd7;
  localparam logic [3:0] LAST_TICK     = 4'd15;
  localparam logic [7:0] ASCII_0       = 8'h30;
  localparam logic [7:0] ASCII_9       = 8'h39;
  localparam int         TIMEOUT_TICKS = 20 * OVERSAMPLE;

  function automatic int baud_count(input int clk_freq, input int baud);
    return clk_freq / (baud * OVERSAMPLE) - 1;
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - rx synchroniser, 16x tick generator and 8N1 receive FSM
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tick,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err
);

  localparam int BC = baud_count(CLK_FREQ, BAUD);
  localparam int CW = (BC > 0) ? $clog2(BC + 1) : 1;

  logic          rx_m, rx_s;
  logic [CW-1:0] baud_cnt;

  rx_state_t     state, state_n;
  logic [3:0]    tick_cnt, tick_cnt_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    rx_data_n;
  logic          rx_valid_n, frame_err_n;

  // Synchroniser idles high so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign tick = (baud_cnt == CW'(BC));

  always_ff @(posedge clk) begin
    if (rst || tick) baud_cnt <= '0;
    else             baud_cnt <= baud_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      tick_cnt  <= tick_cnt_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      frame_err <= frame_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    tick_cnt_n  = tick_cnt;
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    rx_data_n   = rx_data;
    rx_valid_n  = 1'b0;
    frame_err_n = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_n    = START;
            tick_cnt_n = '0;
          end
        end
        START: begin
          // A line that is high again mid start bit was only a glitch.
          if (tick_cnt == MID_SAMPLE) begin
            if (rx_s) begin
              state_n = IDLE;
            end else begin
              state_n    = DATA;
              tick_cnt_n = '0;
              bit_cnt_n  = '0;
            end
          end else begin
            tick_cnt_n = tick_cnt + 4'd1;
          end
        end
        DATA: begin
          if (tick_cnt == LAST_TICK) begin
            shreg_n    = {rx_s, shreg[7:1]};
            tick_cnt_n = '0;
            if (bit_cnt == 3'd7) state_n = STOP;
            else                 bit_cnt_n = bit_cnt + 3'd1;
          end else begin
            tick_cnt_n = tick_cnt + 4'd1;
          end
        end
        STOP: begin
          if (tick_cnt == LAST_TICK) begin
            tick_cnt_n = '0;
            if (rx_s) begin
              rx_data_n  = shreg;
              rx_valid_n = 1'b1;
              state_n    = IDLE;
            end else begin
              frame_err_n = 1'b1;
              state_n     = WAIT_HIGH;
            end
          end else begin
            tick_cnt_n = tick_cnt + 4'd1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: rtl/uart_digit_receiver.sv
// rtl/uart_digit_receiver.sv - UART byte receiver plus fixed-length ASCII decimal assembler
// Optional: define UART_DIGIT_RX_TIMEOUT_EN to drop partial numbers after 20 idle bit-times.
module uart_digit_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int NUM_DIGITS = 3,
  parameter int VALUE_W    = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  output logic               rx_busy,
  output logic               frame_err,
  output logic [VALUE_W-1:0] value,
  output logic               value_valid,
  output logic               digit_err
);

  localparam int DW = $clog2(NUM_DIGITS + 1);

  logic               tick;
  logic               timeout;
  logic [VALUE_W-1:0] acc, acc_next;
  logic [DW-1:0]      dcnt;

  uart_rx_core #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .tick      (tick),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_busy   (rx_busy),
    .frame_err (frame_err)
  );

  assign acc_next = (acc * VALUE_W'(10)) + VALUE_W'(rx_data - ASCII_0);

`ifdef UART_DIGIT_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  logic [TW-1:0] to_cnt;

  assign timeout = tick && (dcnt != '0) && (to_cnt == TW'(TIMEOUT_TICKS - 1));

  always_ff @(posedge clk) begin
    if (rst || rx_valid || (dcnt == '0)) to_cnt <= '0;
    else if (tick)                       to_cnt <= timeout ? '0 : to_cnt + TW'(1);
  end
`else
  logic unused_tick;
  assign unused_tick = tick;
  assign timeout     = 1'b0;
`endif

  // A received byte takes priority over a timeout landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      dcnt        <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      digit_err   <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      digit_err   <= 1'b0;
      if (rx_valid) begin
        if (is_digit(rx_data)) begin
          if (dcnt == DW'(NUM_DIGITS - 1)) begin
            value       <= acc_next;
            value_valid <= 1'b1;
            acc         <= '0;
            dcnt        <= '0;
          end else begin
            acc  <= acc_next;
            dcnt <= dcnt + DW'(1);
          end
        end else begin
          digit_err <= 1'b1;
          acc       <= '0;
          dcnt      <= '0;
        end
      end else if (frame_err || timeout) begin
        acc  <= '0;
        dcnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_digit_receiver.sv
// tb/tb_uart_digit_receiver.sv - bench for uart_digit_receiver with a byte/number scoreboard model
module tb_uart_digit_receiver;

  localparam int CLK_FREQ   = 614400;
  localparam int BAUD       = 9600;
  localparam int NUM_DIGITS = 3;
  localparam int VALUE_W    = 10;
  localparam int BIT_CLK    = CLK_FREQ / BAUD;
`ifdef UART_DIGIT_RX_TIMEOUT_EN
  localparam int TIMEOUT_CLK = 20 * BIT_CLK;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               rx  = 1'b1;
  logic [7:0]         rx_data;
  logic               rx_valid, rx_busy, frame_err;
  logic [VALUE_W-1:0] value;
  logic               value_valid, digit_err;

  uart_digit_receiver #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .NUM_DIGITS (NUM_DIGITS),
    .VALUE_W    (VALUE_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_busy     (rx_busy),
    .frame_err   (frame_err),
    .value       (value),
    .value_valid (value_valid),
    .digit_err   (digit_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit         err;
    logic [7:0] data;
  } ev_t;

  ev_t                exp_q[$];
  ev_t                ev;
  int                 m_digits[$];
  logic [7:0]         m_rx_data;
  logic [VALUE_W-1:0] m_value, nxt_value;
  bit                 nxt_vv, nxt_de, cur_vv, cur_de;
  bit                 rst_q;
  int                 idle_clk;
  int                 busy_cycles, rx_valid_cnt, frame_err_cnt, vv_cnt, de_cnt;

  always @(posedge clk) rst_q <= rst;

  always @(negedge clk) begin
    if (rst_q) begin
      m_rx_data = '0;
      m_value   = '0;
      m_digits.delete();
      nxt_vv    = 1'b0;
      nxt_de    = 1'b0;
      idle_clk  = 0;
    end
    cur_vv = nxt_vv;
    cur_de = nxt_de;
    if (nxt_vv) m_value = nxt_value;
    nxt_vv = 1'b0;
    nxt_de = 1'b0;
    check("value_valid", 32'(value_valid), 32'(cur_vv));
    check("digit_err", 32'(digit_err), 32'(cur_de));
    check("value", 32'(value), 32'(m_value));

    if (rx_busy)     busy_cycles++;
    if (rx_valid)    rx_valid_cnt++;
    if (frame_err)   frame_err_cnt++;
    if (value_valid) vv_cnt++;
    if (digit_err)   de_cnt++;

    if (rx_valid || frame_err) begin
      check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        ev = exp_q.pop_front();
        check("frame_err_pulse", 32'(frame_err), 32'(ev.err));
        check("rx_valid_pulse", 32'(rx_valid), 32'(!ev.err));
        idle_clk = 0;
        if (ev.err) begin
          m_digits.delete();
        end else begin
          m_rx_data = ev.data;
          if (ev.data >= 8'h30 && ev.data <= 8'h39) begin
            m_digits.push_back(int'(ev.data) - 48);
            if (m_digits.size() == NUM_DIGITS) begin
              int v;
              v = 0;
              foreach (m_digits[k]) v += m_digits[k] * (10 ** (NUM_DIGITS - 1 - k));
              nxt_vv    = 1'b1;
              nxt_value = VALUE_W'(v);
              m_digits.delete();
            end
          end else begin
            nxt_de = 1'b1;
            m_digits.delete();
          end
        end
      end
    end else if (m_digits.size() != 0) begin
      idle_clk++;
`ifdef UART_DIGIT_RX_TIMEOUT_EN
      if (idle_clk > TIMEOUT_CLK) m_digits.delete();
`endif
    end
    check("rx_data", 32'(rx_data), 32'(m_rx_data));
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    cycles(BIT_CLK);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int gap_bits);
    exp_q.push_back('{err: !stop_ok, data: b});
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    rx = 1'b1;
    cycles(gap_bits * BIT_CLK);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check({tag, "_rx_busy"}, 32'(rx_busy), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_value"}, 32'(value), 32'd0);
    check({tag, "_value_valid"}, 32'(value_valid), 32'd0);
    check({tag, "_digit_err"}, 32'(digit_err), 32'd0);
  endtask

  task automatic do_reset();
    rx  = 1'b1;
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check_reset_outputs("reset");
  endtask

  initial begin
    int rv0, fe0, vv0, de0;
    #1;
    rst = 1'b1;
    rx  = 1'b1;
    cycles(3);
    rst = 1'b0;
    check_reset_outputs("init");
    cycles(2 * BIT_CLK);

    // Single 0x35 frame: one byte, exact busy window of 9.5 bit-times.
    rv0 = rx_valid_cnt; fe0 = frame_err_cnt; de0 = de_cnt;
    busy_cycles = 0;
    send_frame(8'h35, 1'b1, 2);
    check("byte35_count", 32'(rx_valid_cnt - rv0), 32'd1);
    check("byte35_data", 32'(rx_data), 32'h35);
    check("byte35_busy_cycles", 32'(busy_cycles), 32'(BIT_CLK * 19 / 2));
    check("byte35_no_frame_err", 32'(frame_err_cnt - fe0), 32'd0);
    check("byte35_no_digit_err", 32'(de_cnt - de0), 32'd0);
    do_reset();

    // Three complete numbers.
    vv0 = vv_cnt;
    send_frame(8'h31, 1'b1, 1); send_frame(8'h32, 1'b1, 1); send_frame(8'h33, 1'b1, 1);
    check("num_123", 32'(value), 32'd123);
    send_frame(8'h35, 1'b1, 1); send_frame(8'h31, 1'b1, 1); send_frame(8'h31, 1'b1, 1);
    check("num_511", 32'(value), 32'd511);
    send_frame(8'h39, 1'b1, 1); send_frame(8'h39, 1'b1, 1); send_frame(8'h39, 1'b1, 1);
    check("num_999", 32'(value), 32'd999);
    check("num_valid_count", 32'(vv_cnt - vv0), 32'd3);

    // Start-bit glitch of 3 ticks, then a real 0x30.
    rv0 = rx_valid_cnt; fe0 = frame_err_cnt;
    rx = 1'b0;
    cycles(3 * BIT_CLK / 16);
    rx = 1'b1;
    cycles(BIT_CLK * 2);
    check("glitch_idle", 32'(rx_busy), 32'd0);
    check("glitch_no_rx_valid", 32'(rx_valid_cnt - rv0), 32'd0);
    check("glitch_no_frame_err", 32'(frame_err_cnt - fe0), 32'd0);
    send_frame(8'h30, 1'b1, 1);
    check("after_glitch_data", 32'(rx_data), 32'h30);

    // Framing error discards the partial number.
    fe0 = frame_err_cnt;
    send_frame(8'h31, 1'b1, 1);
    send_frame(8'h32, 1'b0, 1);
    send_frame(8'h32, 1'b1, 1); send_frame(8'h33, 1'b1, 1); send_frame(8'h34, 1'b1, 1);
    check("frame_err_count", 32'(frame_err_cnt - fe0), 32'd1);
    check("num_234", 32'(value), 32'd234);

    // Non-digit in the middle of a number.
    de0 = de_cnt;
    send_frame(8'h31, 1'b1, 1); send_frame(8'h41, 1'b1, 1);
    check("digit_err_count", 32'(de_cnt - de0), 32'd1);
    send_frame(8'h30, 1'b1, 1); send_frame(8'h30, 1'b1, 1); send_frame(8'h37, 1'b1, 1);
    check("num_007", 32'(value), 32'd7);
    check("digit_err_once", 32'(de_cnt - de0), 32'd1);

    // Reset during data bit 4 of a 0x39 frame, then a clean 0x39.
    rv0 = rx_valid_cnt; fe0 = frame_err_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h39 >> i));
    rx = 1'b1;
    cycles(BIT_CLK / 2);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check_reset_outputs("midframe");
    cycles(2 * BIT_CLK);
    check("abort_no_rx_valid", 32'(rx_valid_cnt - rv0), 32'd0);
    check("abort_no_frame_err", 32'(frame_err_cnt - fe0), 32'd0);
    send_frame(8'h39, 1'b1, 1);
    check("after_abort_count", 32'(rx_valid_cnt - rv0), 32'd1);
    check("after_abort_data", 32'(rx_data), 32'h39);
    do_reset();

    // Long pause after the first digit.
    send_frame(8'h34, 1'b1, 30);
    send_frame(8'h35, 1'b1, 1); send_frame(8'h36, 1'b1, 1); send_frame(8'h37, 1'b1, 1);
`ifdef UART_DIGIT_RX_TIMEOUT_EN
    check("timeout_num", 32'(value), 32'd567);
`else
    check("timeout_num", 32'(value), 32'd456);
`endif

    // Randomized traffic: mostly digits, some junk bytes, some broken frames, some long pauses.
    for (int i = 0; i < 30; i++) begin
      int         sel, gap;
      logic [7:0] b;
      sel = int'($urandom_range(0, 9));
      gap = ($urandom_range(0, 6) == 0) ? 30 : int'($urandom_range(1, 4));
      if (sel < 8) begin
        b = 8'h30 + 8'($urandom_range(0, 9));
      end else begin
        b = 8'($urandom_range(0, 255));
        if (sel == 8 && b >= 8'h30 && b <= 8'h39) b = 8'h7a;
      end
      send_frame(b, sel != 9, gap);
    end

    cycles(2 * BIT_CLK);
    check("all_events_seen", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
